onchip_ram_arbiter: RTL and testbench

- Shares the s1 port (single clock domain) of the 128K-word x 32-bit dual-port on-chip RAM between two Avalon-MM requesters, m0 and m1.
- Round-robin arbitration with a per-owner transfer quantum, zero-bubble switching and one-cycle pipelined reads.
- Sits between the two masters and the RAM's address/byteenable/chipselect/write/writedata/clken/readdata pins. Port s2 is untouched.

---
 rtl/onchip_ram_arb_pkg.sv | 18 +
 rtl/onchip_ram_arb_perfcnt.sv | 32 +++
 rtl/onchip_ram_arbiter.sv | 171 +++++++++++++++++
 tb/tb_onchip_ram_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_ram_arb_pkg.sv
// Shared types and constants for the on-chip RAM s1-port arbiter.
package onchip_ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_e;

  localparam int ADDR_W_DEF = 17;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W      = 32;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/onchip_ram_arb_perfcnt.sv
// Saturating performance counter with synchronous clear and increment enable.
module onchip_ram_arb_perfcnt
  import onchip_ram_arb_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear wins over a coincident increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/onchip_ram_arbiter.sv
// Round-robin arbiter sharing one RAM port between two Avalon-MM requesters.
// Optional performance counters enabled by defining ONCHIP_RAM_ARB_PERF_CNT_EN.
module onchip_ram_arbiter
  import onchip_ram_arb_pkg::*;
#(
  parameter  int ADDR_W  = ADDR_W_DEF,
  parameter  int DATA_W  = DATA_W_DEF,
  parameter  int QUANTUM = 4,
  localparam int BE_W    = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,

  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata,

  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [7:0] QLIM = 8'(QUANTUM - 1);

  owner_e     state_q, state_d;
  logic       last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_id_q, rd_id_d;

  logic req0, req1, grant0, grant1, cnt_ok;

  assign req0   = m0_read | m0_write;
  assign req1   = m1_read | m1_write;
  assign cnt_ok = (cnt_q < QLIM);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    grant0  = 1'b0;
    grant1  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // last_q == 1 means m1 owned last, so m0 wins a tie.
        if (req0 && (!req1 || last_q)) begin
          grant0  = 1'b1;
          state_d = OWN0;
          cnt_d   = '0;
        end else if (req1) begin
          grant1  = 1'b1;
          state_d = OWN1;
          cnt_d   = '0;
        end
      end
      OWN0: begin
        if (req0 && (!req1 || cnt_ok)) begin
          grant0 = 1'b1;
          cnt_d  = sat_inc8(cnt_q);
        end else if (req1) begin
          grant1  = 1'b1;
          state_d = OWN1;
          cnt_d   = '0;
          last_d  = 1'b0;
        end else begin
          state_d = IDLE;
          last_d  = 1'b0;
        end
      end
      OWN1: begin
        if (req1 && (!req0 || cnt_ok)) begin
          grant1 = 1'b1;
          cnt_d  = sat_inc8(cnt_q);
        end else if (req0) begin
          grant0  = 1'b1;
          state_d = OWN0;
          cnt_d   = '0;
          last_d  = 1'b1;
        end else begin
          state_d = IDLE;
          last_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A request carrying both read and write is treated as a write.
  assign rd_pend_d = (grant0 & m0_read & ~m0_write) | (grant1 & m1_read & ~m1_write);
  assign rd_id_d   = grant1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      rd_pend_q <= 1'b0;
      rd_id_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      rd_pend_q <= rd_pend_d;
      rd_id_q   <= rd_id_d;
    end
  end

  assign m0_waitrequest = req0 & ~grant0;
  assign m1_waitrequest = req1 & ~grant1;

  assign ram_address    = grant1 ? m1_address    : m0_address;
  assign ram_byteenable = grant1 ? m1_byteenable : m0_byteenable;
  assign ram_writedata  = grant1 ? m1_writedata  : m0_writedata;
  assign ram_write      = (grant0 & m0_write) | (grant1 & m1_write);
  assign ram_chipselect = grant0 | grant1;
  assign ram_clken      = 1'b1;

  // Both masters see the RAM output; only the valid strobe is steered.
  assign m0_readdata      = ram_readdata;
  assign m1_readdata      = ram_readdata;
  assign m0_readdatavalid = rd_pend_q & ~rd_id_q;
  assign m1_readdatavalid = rd_pend_q &  rd_id_q;

`ifdef ONCHIP_RAM_ARB_PERF_CNT_EN
  logic stall;
  assign stall = m0_waitrequest | m1_waitrequest;

  onchip_ram_arb_perfcnt u_cnt_g0 (
    .clk_i(clk), .rst_ni(reset_n), .clr_i(clr_cnt), .inc_i(grant0), .cnt_o(grant_cnt0)
  );
  onchip_ram_arb_perfcnt u_cnt_g1 (
    .clk_i(clk), .rst_ni(reset_n), .clr_i(clr_cnt), .inc_i(grant1), .cnt_o(grant_cnt1)
  );
  onchip_ram_arb_perfcnt u_cnt_st (
    .clk_i(clk), .rst_ni(reset_n), .clr_i(clr_cnt), .inc_i(stall), .cnt_o(stall_cnt)
  );
`else
  logic unused_clr_cnt;
  assign unused_clr_cnt = clr_cnt;
  assign grant_cnt0     = '0;
  assign grant_cnt1     = '0;
  assign stall_cnt      = '0;
`endif

  assert property (@(posedge clk) disable iff (!reset_n)
    !(m0_read && m0_write) && !(m1_read && m1_write));

endmodule

// File: tb/tb_onchip_ram_arbiter.sv
// Directed bench for onchip_ram_arbiter with a behavioural RAM on the s1 side.
module tb_onchip_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [16:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [16:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [31:0] ram_writedata;
  logic [31:0] ram_readdata = '0;
  logic        clr_cnt;
  logic [31:0] grant_cnt0, grant_cnt1, stall_cnt;

  logic        q1_m0_wait, q1_m1_wait;
  logic [31:0] unused_q1_rd0, unused_q1_rd1, unused_q1_wd, unused_q1_g0, unused_q1_g1, unused_q1_st;
  logic        unused_q1_rv0, unused_q1_rv1, unused_q1_cs, unused_q1_we, unused_q1_ce;
  logic [16:0] unused_q1_addr;
  logic [3:0]  unused_q1_be;

  logic [31:0] mem [0:131071];

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  onchip_ram_arbiter #(.ADDR_W(17), .DATA_W(32), .QUANTUM(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable), .ram_chipselect(ram_chipselect),
    .ram_write(ram_write), .ram_writedata(ram_writedata), .ram_clken(ram_clken),
    .ram_readdata(ram_readdata),
    .clr_cnt(clr_cnt), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .stall_cnt(stall_cnt)
  );

  // Second instance with the minimum quantum; only its waitrequests are observed.
  onchip_ram_arbiter #(.ADDR_W(17), .DATA_W(32), .QUANTUM(1)) dut_q1 (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(q1_m0_wait),
    .m0_readdata(unused_q1_rd0), .m0_readdatavalid(unused_q1_rv0),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(q1_m1_wait),
    .m1_readdata(unused_q1_rd1), .m1_readdatavalid(unused_q1_rv1),
    .ram_address(unused_q1_addr), .ram_byteenable(unused_q1_be), .ram_chipselect(unused_q1_cs),
    .ram_write(unused_q1_we), .ram_writedata(unused_q1_wd), .ram_clken(unused_q1_ce),
    .ram_readdata(32'h0),
    .clr_cnt(clr_cnt), .grant_cnt0(unused_q1_g0), .grant_cnt1(unused_q1_g1), .stall_cnt(unused_q1_st)
  );

  // Single-cycle synchronous RAM with byte enables.
  always @(posedge clk) begin
    if (ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) mem[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
      end
      ram_readdata <= mem[ram_address];
    end
  end

  function automatic logic [31:0] pat(input int a);
    return 32'hC0DE_0000 ^ 32'(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  int          exp_own, prev_own, n0, n1;
  logic [31:0] prev_data, exp_g, exp_st;

  initial begin
    for (int a = 16'h100; a < 16'h500; a++) mem[a] = pat(a);
    reset_n = 0; clr_cnt = 0;
    m0_address = '0; m0_byteenable = 4'hF; m0_writedata = '0;
    m1_address = '0; m1_byteenable = 4'hF; m1_writedata = '0;
    idle_inputs();

    // Reset state
    @(negedge clk);
    chk("rst_m0_wait", 32'(m0_waitrequest), 0);
    chk("rst_m1_wait", 32'(m1_waitrequest), 0);
    chk("rst_rdv", 32'({m0_readdatavalid, m1_readdatavalid}), 0);
    chk("rst_cs_we", 32'({ram_chipselect, ram_write}), 0);
    chk("rst_clken", 32'(ram_clken), 1);
    chk("rst_cnt", grant_cnt0 | grant_cnt1 | stall_cnt, 0);
    reset_n = 1;
    next_cycle();

    // m0 writes then reads back a word
    m0_write = 1; m0_address = 17'h10; m0_byteenable = 4'hF; m0_writedata = 32'hDEADBEEF;
    @(negedge clk);
    chk("wr_wait", 32'(m0_waitrequest), 0);
    chk("wr_ram_drive", 32'({ram_chipselect, ram_write}), 32'b11);
    chk("wr_ram_addr", 32'(ram_address), 32'h10);
    chk("wr_ram_data", ram_writedata, 32'hDEADBEEF);
    next_cycle();
    m0_write = 0; m0_read = 1;
    @(negedge clk);
    chk("rd_wait", 32'(m0_waitrequest), 0);
    chk("rd_rdv_early", 32'(m0_readdatavalid), 0);
    chk("rd_ram_we", 32'({ram_chipselect, ram_write}), 32'b10);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk("rd_rdv", 32'({m0_readdatavalid, m1_readdatavalid}), 32'b10);
    chk("rd_data", m0_readdata, 32'hDEADBEEF);
    chk("idle_cs", 32'(ram_chipselect), 0);
    next_cycle();
    @(negedge clk);
    chk("rd_rdv_once", 32'(m0_readdatavalid), 0);
    next_cycle();

    // Partial write by m0 over m1's full word, then m1 reads it
    m1_write = 1; m1_address = 17'h20; m1_byteenable = 4'hF; m1_writedata = 32'hAAAABBBB;
    next_cycle();
    idle_inputs();
    m0_write = 1; m0_address = 17'h20; m0_byteenable = 4'h3; m0_writedata = 32'h11112222;
    next_cycle();
    idle_inputs();
    m1_read = 1; m1_address = 17'h20;
    @(negedge clk);
    chk("be_m1_wait", 32'(m1_waitrequest), 0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk("be_rdv", 32'({m0_readdatavalid, m1_readdatavalid}), 32'b01);
    chk("be_data", m1_readdata, 32'hAAAA2222);
    next_cycle();

    // Read accepted, then reset before the valid cycle completes
    m0_read = 1; m0_address = 17'h10;
    @(negedge clk);
    chk("rstmid_acc", 32'(m0_waitrequest), 0);
    next_cycle();
    idle_inputs();
    reset_n = 0;
    @(negedge clk);
    chk("rstmid_rdv", 32'({m0_readdatavalid, m1_readdatavalid}), 0);
    reset_n = 1;
    next_cycle();

    // First contention after reset: m0 wins, m1 follows with no bubble
    m0_read = 1; m0_address = 17'h110; m1_read = 1; m1_address = 17'h210;
    @(negedge clk);
    chk("tie_m0_wait", 32'(m0_waitrequest), 0);
    chk("tie_m1_wait", 32'(m1_waitrequest), 1);
    next_cycle();
    m0_read = 0;
    @(negedge clk);
    chk("tie_m1_grant", 32'(m1_waitrequest), 0);
    chk("tie_rdv0", 32'({m0_readdatavalid, m1_readdatavalid}), 32'b10);
    chk("tie_data0", m0_readdata, pat(16'h110));
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk("tie_rdv1", 32'({m0_readdatavalid, m1_readdatavalid}), 32'b01);
    chk("tie_data1", m1_readdata, pat(16'h210));
    next_cycle();

    // Clear counters, then continuous contention from both masters
    clr_cnt = 1;
    next_cycle();
    clr_cnt = 0;
    n0 = 0; n1 = 0; prev_own = -1; prev_data = '0;
`ifdef ONCHIP_RAM_ARB_PERF_CNT_EN
    exp_g = 32'd10; exp_st = 32'd10;
`else
    exp_g = 32'd0;  exp_st = 32'd0;
`endif
    for (int k = 0; k < 12; k++) begin
      exp_own = (k / 4) % 2;
      m0_read = 1; m0_address = 17'(16'h300 + n0);
      m1_read = 1; m1_address = 17'(16'h400 + n1);
      @(negedge clk);
      chk($sformatf("rr_m0_wait_%0d", k), 32'(m0_waitrequest), 32'(exp_own == 1));
      chk($sformatf("rr_m1_wait_%0d", k), 32'(m1_waitrequest), 32'(exp_own == 0));
      chk($sformatf("rr_cs_%0d", k), 32'(ram_chipselect), 1);
      chk($sformatf("q1_m0_wait_%0d", k), 32'(q1_m0_wait), 32'(k % 2));
      chk($sformatf("q1_m1_wait_%0d", k), 32'(q1_m1_wait), 32'((k + 1) % 2));
      if (k > 0) begin
        chk($sformatf("rr_rdv_%0d", k), 32'({m0_readdatavalid, m1_readdatavalid}),
            (prev_own == 0) ? 32'b10 : 32'b01);
        chk($sformatf("rr_data_%0d", k), (prev_own == 0) ? m0_readdata : m1_readdata, prev_data);
      end
      if (k == 10) begin
        chk("perf_grants", grant_cnt0 + grant_cnt1, exp_g);
        chk("perf_stall", stall_cnt, exp_st);
      end
      prev_own = exp_own;
      if (exp_own == 0) begin prev_data = pat(16'h300 + n0); n0++; end
      else              begin prev_data = pat(16'h400 + n1); n1++; end
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    chk("rr_rdv_last", 32'({m0_readdatavalid, m1_readdatavalid}), (prev_own == 0) ? 32'b10 : 32'b01);
    chk("rr_data_last", (prev_own == 0) ? m0_readdata : m1_readdata, prev_data);
    clr_cnt = 1;
    next_cycle();
    clr_cnt = 0;
    @(negedge clk);
    chk("clr_g0", grant_cnt0, 0);
    chk("clr_g1", grant_cnt1, 0);
    chk("clr_st", stall_cnt, 0);
    next_cycle();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
